// File: rtl/lu_sequencer.sv
// Program sequencer for lu_fudge: fetches ROM words, issues opcode/io_addr, and
// redirects on jmp/rtn/flgf pulses using a hardware return stack and a halt state.
module lu_sequencer #(
   parameter int unsigned PC_W        = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned WAIT_MAX    = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W+3:0] prog_data,
   output logic [PC_W-1:0] pc,
   output logic [3:0]      instruction,
   output logic [PC_W-1:0] io_addr,
   input  logic            jmp,
   input  logic            rtn,
   input  logic            flgf,
   input  logic            run,
   output logic            halted,
   output logic            stk_ovf,
   output logic            stk_unf,
   output logic            seq_err
);

   localparam int unsigned SP_AW = $clog2(STACK_DEPTH);
   localparam int unsigned SP_W  = SP_AW + 1;
   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

   localparam logic [3:0] OP_NOPO = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_NOPF = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH    = 3'd0,
      ST_WAIT_JMP = 3'd1,
      ST_WAIT_RTN = 3'd2,
      ST_WAIT_HLT = 3'd3,
      ST_HALT     = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [3:0]       instr_q, instr_d;
   logic [PC_W-1:0]  io_addr_q, io_addr_d;
   logic [PC_W-1:0]  target_q, target_d;
   logic [SP_W-1:0]  sp_q, sp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q, halted_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             err_q, err_d;
   logic [PC_W-1:0]  stack_q [STACK_DEPTH];
   logic [PC_W-1:0]  stack_d [STACK_DEPTH];

   logic [3:0]       opcode;
   logic [PC_W-1:0]  operand;
   logic [SP_W-1:0]  sp_m1;
   logic             any_pulse;
   logic             wait_hit;
   logic             wait_other;

   assign opcode    = prog_data[PC_W+3:PC_W];
   assign operand   = prog_data[PC_W-1:0];
   assign sp_m1     = sp_q - SP_W'(1);
   assign any_pulse = jmp | rtn | flgf;

   // Next-state and datapath decode
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      io_addr_d = io_addr_q;
      target_d  = target_q;
      sp_d      = sp_q;
      cnt_d     = cnt_q;
      halted_d  = halted_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      err_d     = err_q;
      stack_d   = stack_q;
      wait_hit   = 1'b0;
      wait_other = 1'b0;

      case (state_q)
         ST_FETCH: begin
            instr_d   = opcode;
            io_addr_d = operand;
            pc_d      = pc_q + PC_W'(1);
            cnt_d     = '0;
            if (any_pulse) err_d = 1'b1;
            case (opcode)
               OP_JMP: begin
                  target_d = operand;
                  state_d  = ST_WAIT_JMP;
               end
               OP_RTN:  state_d = ST_WAIT_RTN;
               OP_NOPF: state_d = ST_WAIT_HLT;
               default: state_d = ST_FETCH;
            endcase
         end

         ST_WAIT_JMP, ST_WAIT_RTN, ST_WAIT_HLT: begin
            instr_d = OP_NOPO;
            cnt_d   = cnt_q + CNT_W'(1);
            case (state_q)
               ST_WAIT_JMP: begin
                  wait_hit   = jmp;
                  wait_other = rtn | flgf;
               end
               ST_WAIT_RTN: begin
                  wait_hit   = rtn;
                  wait_other = jmp | flgf;
               end
               default: begin
                  wait_hit   = flgf;
                  wait_other = jmp | rtn;
               end
            endcase
            if (wait_other) err_d = 1'b1;

            if (wait_hit) begin
               state_d = ST_FETCH;
               case (state_q)
                  ST_WAIT_JMP: begin
                     // A full stack loses the return address but the call still redirects
                     if (sp_q == SP_W'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                     end else begin
                        stack_d[sp_q[SP_AW-1:0]] = pc_q;
                        sp_d = sp_q + SP_W'(1);
                     end
                     pc_d = target_q;
                  end
                  ST_WAIT_RTN: begin
                     if (sp_q == '0) begin
                        unf_d = 1'b1;
                     end else begin
                        pc_d = stack_q[sp_m1[SP_AW-1:0]];
                        sp_d = sp_m1;
                     end
                  end
                  default: begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                  end
               endcase
            end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = ST_FETCH;
            end
         end

         ST_HALT: begin
            instr_d = OP_NOPO;
            if (any_pulse) err_d = 1'b1;
            if (run) begin
               state_d  = ST_FETCH;
               halted_d = 1'b0;
            end
         end

         default: state_d = ST_FETCH;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         pc_q      <= '0;
         instr_q   <= OP_NOPO;
         io_addr_q <= '0;
         target_q  <= '0;
         sp_q      <= '0;
         cnt_q     <= '0;
         halted_q  <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         err_q     <= 1'b0;
         stack_q   <= '{default: '0};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         io_addr_q <= io_addr_d;
         target_q  <= target_d;
         sp_q      <= sp_d;
         cnt_q     <= cnt_d;
         halted_q  <= halted_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         err_q     <= err_d;
         stack_q   <= stack_d;
      end
   end

   assign pc          = pc_q;
   assign instruction = instr_q;
   assign io_addr     = io_addr_q;
   assign halted      = halted_q;
   assign stk_ovf     = ovf_q;
   assign stk_unf     = unf_q;
   assign seq_err     = err_q;

endmodule

// File: tb/tb_lu_sequencer.sv
// Scoreboard bench for lu_sequencer: stimulus queues per-edge expectations,
// a monitor on the falling edge pops and compares them against the outputs.
module tb_lu_sequencer;

   localparam int unsigned PC_W = 8;

   logic            clk = 1'b0;
   logic            reset, jmp, rtn, flgf, run;
   logic [PC_W+3:0] prog_data;
   logic [PC_W-1:0] pc, io_addr;
   logic [3:0]      instruction;
   logic            halted, stk_ovf, stk_unf, seq_err;
   logic [PC_W+3:0] rom [256];

   lu_sequencer #(.PC_W(PC_W), .STACK_DEPTH(4), .WAIT_MAX(3)) dut (
      .clk(clk), .reset(reset), .prog_data(prog_data), .pc(pc),
      .instruction(instruction), .io_addr(io_addr), .jmp(jmp), .rtn(rtn),
      .flgf(flgf), .run(run), .halted(halted), .stk_ovf(stk_ovf),
      .stk_unf(stk_unf), .seq_err(seq_err)
   );

   assign prog_data = rom[pc];
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int    cyc;
      string nm;
      int    pc, ins, io, hlt, ovf, unf, err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Expected outputs after the next rising edge; -1 means don't care
   task automatic exp1(input string nm, input int e_pc, input int e_ins, input int e_io,
                       input int e_hlt, input int e_ovf, input int e_unf, input int e_err);
      exp_t e;
      e.cyc = edge_cnt + 1; e.nm = nm;
      e.pc = e_pc; e.ins = e_ins; e.io = e_io;
      e.hlt = e_hlt; e.ovf = e_ovf; e.unf = e_unf; e.err = e_err;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input string f, input int got, input int want);
      if (want >= 0) begin
         n_checks++;
         if (got == want) n_pass++;
         else $display("FAIL %s.%s: got %0h, want %0h", nm, f, got, want);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < edge_cnt) begin
               n_checks++;
               $display("FAIL %s: stale, due cycle %0d seen at %0d", mon_e.nm, mon_e.cyc, edge_cnt);
            end else begin
               cmp(mon_e.nm, "pc",      int'(pc),          mon_e.pc);
               cmp(mon_e.nm, "instr",   int'(instruction), mon_e.ins);
               cmp(mon_e.nm, "io_addr", int'(io_addr),     mon_e.io);
               cmp(mon_e.nm, "halted",  int'(halted),      mon_e.hlt);
               cmp(mon_e.nm, "stk_ovf", int'(stk_ovf),     mon_e.ovf);
               cmp(mon_e.nm, "stk_unf", int'(stk_unf),     mon_e.unf);
               cmp(mon_e.nm, "seq_err", int'(seq_err),     mon_e.err);
            end
         end
      end
   end

   // The bench plays lu_fudge: jmp is raised after E1 so it is sampled at E2
   task automatic call_seq(input int tgt, input int ret, input int e_ovf);
      exp1("call_issue", ret, 12, tgt, -1, -1, -1, -1);
      tick();
      exp1("call_wait", ret, 0, -1, -1, -1, -1, -1);
      tick();
      jmp = 1'b1;
      exp1("call_pc", tgt, 0, -1, 0, e_ovf, -1, 0);
      tick();
      jmp = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = {4'h1, PC_W'(i)};
      rom[1]     = {4'h3, 8'h01};
      rom[2]     = {4'h5, 8'h02};
      rom[4]     = {4'hC, 8'h20};
      rom[5]     = {4'hC, 8'h40};
      rom[8'h25] = {4'hD, 8'h00};
      rom[8'h40] = {4'hC, 8'h41};
      rom[8'h41] = {4'hC, 8'h42};
      rom[8'h42] = {4'hC, 8'h43};
      rom[8'h43] = {4'hC, 8'h44};
      rom[8'h10] = {4'hF, 8'h10};
      rom[8'h11] = {4'h2, 8'h11};
      rom[8'h12] = {4'hC, 8'h50};
      rom[8'h14] = {4'hD, 8'h00};

      reset = 1'b1; jmp = 1'b0; rtn = 1'b0; flgf = 1'b0; run = 1'b0;
      exp1("reset", 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;

      exp1("lin0", 1, 1, 0, 0, 0, 0, 0); tick();
      exp1("lin1", 2, 3, 1, 0, 0, 0, 0); tick();
      exp1("lin2", 3, 5, 2, 0, 0, 0, 0); tick();
      exp1("lin3", 4, 1, 3, 0, 0, 0, 0); tick();

      call_seq(8'h20, 5, 0);
      exp1("tgt_fetch", 8'h21, 1, 8'h20, 0, 0, 0, 0); tick();
      repeat (4) tick();
      exp1("rtn_issue", 8'h26, 13, 0, 0, 0, 0, 0); tick();
      exp1("rtn_wait", 8'h26, 0, -1, 0, 0, 0, 0); tick();
      rtn = 1'b1;
      exp1("rtn_pc", 5, 0, -1, 0, 0, 0, 0); tick();
      rtn = 1'b0;

      call_seq(8'h40, 6, 0);
      call_seq(8'h41, 8'h41, 0);
      call_seq(8'h42, 8'h42, 0);
      call_seq(8'h43, 8'h43, 0);
      call_seq(8'h44, 8'h44, 1);
      exp1("ovf_sticky", 8'h45, 1, 8'h44, 0, 1, 0, 0); tick();

      reset = 1'b1;
      exp1("reset2", 0, 0, 0, 0, 0, 0, 0); tick();
      reset = 1'b0;
      rom[0] = {4'hD, 8'h00};
      rom[1] = {4'hC, 8'h10};
      exp1("unf_issue", 1, 13, 0, 0, 0, 0, 0); tick();
      exp1("unf_wait", 1, 0, -1, 0, 0, 0, 0); tick();
      rtn = 1'b1;
      exp1("unf_pc", 1, 0, -1, 0, 0, 1, 0); tick();
      rtn = 1'b0;

      call_seq(8'h10, 2, 0);
      exp1("nopf_issue", 8'h11, 15, 8'h10, 0, 0, 1, 0); tick();
      exp1("nopf_wait", 8'h11, 0, -1, 0, 0, 1, 0); tick();
      flgf = 1'b1;
      exp1("halt_enter", 8'h11, 0, -1, 1, 0, 1, 0); tick();
      flgf = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp1("halt_hold", 8'h11, 0, -1, 1, 0, 1, 0); tick();
      end
      run = 1'b1;
      exp1("run_exit", 8'h11, 0, -1, 0, 0, 1, 0); tick();
      run = 1'b0;
      exp1("resume", 8'h12, 2, 8'h11, 0, 0, 1, 0); tick();

      exp1("to_issue", 8'h13, 12, 8'h50, 0, 0, 1, 0); tick();
      exp1("to_w1", 8'h13, 0, -1, 0, 0, 1, 0); tick();
      exp1("to_w2", 8'h13, 0, -1, 0, 0, 1, 0); tick();
      exp1("to_err", 8'h13, 0, -1, 0, 0, 1, 1); tick();
      exp1("to_resume", 8'h14, 1, 8'h13, 0, 0, 1, 1); tick();

      exp1("rtn2_issue", 8'h15, 13, 0, 0, 0, 1, 1); tick();
      reset = 1'b1;
      exp1("reset_wait", 0, 0, 0, 0, 0, 0, 0); tick();
      reset = 1'b0;

      rom[0] = {4'h1, 8'h00};
      jmp = 1'b1;
      exp1("fetch_pulse", 1, 1, 0, 0, 0, 0, 1); tick();
      jmp = 1'b0;

      tick();
      tick();
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
